// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - SFR map, status bit and FSM encoding shared by the SPI transfer sequencer
package spi_seq_pkg;

  localparam logic [2:0] ADDR_DR1_W = 3'b011;
  localparam logic [2:0] ADDR_SR_R  = 3'b011;
  localparam logic [2:0] ADDR_DR2_R = 3'b101;

  localparam int SR_MDONE_BIT = 0;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 2'd0;
  localparam seq_state_t ST_WR_DATA   = 2'd1;
  localparam seq_state_t ST_WAIT_DONE = 2'd2;
  localparam seq_state_t ST_RD_DATA   = 2'd3;

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - power-of-two synchronous FIFO; push while full is taken when a pop frees the slot
module spi_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - streams TX bytes through the SPI SFR block and collects replies into an RX FIFO
// Optional WAIT_DONE timeout with sticky tmo_err when SPI_SEQ_TIMEOUT_EN is defined.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seq_en,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   sfrwe,
  output logic [2:0]             sfraddr_w,
  output logic [7:0]             spidata_o,
  output logic [2:0]             sfraddr_r,
  input  logic [7:0]             sfrdatai,
  output logic                   busy,
`ifdef SPI_SEQ_TIMEOUT_EN
  output logic                   tmo_err,
`endif
  output logic [$clog2(DEPTH):0] tx_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  seq_state_t    state;
  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic [LW-1:0] rx_level;
  logic          rx_slot_free;
  logic          done_q, done_rise, start, tmo_hit;

  assign tx_pop       = (state == ST_WR_DATA);
  assign tx_ready     = ~tx_full | tx_pop;
  assign tx_push      = tx_valid & tx_ready;
  assign rx_push      = (state == ST_RD_DATA);
  assign rx_valid     = ~rx_empty;
  assign rx_pop       = rx_valid & rx_ready;
  assign rx_slot_free = ~rx_full && (rx_level < LW'(DEPTH));
  assign done_rise    = sfrdatai[SR_MDONE_BIT] & ~done_q & (sfraddr_r == ADDR_SR_R);
  // Starting only with a free RX slot means the reply always has somewhere to land.
  assign start        = seq_en & ~tx_empty & rx_slot_free;
  assign busy         = (state != ST_IDLE) | ~tx_empty;

  spi_seq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(tx_data),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_seq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(sfrdatai),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_WAIT_DONE) & ~done_rise & (tmo_cnt <= TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == ST_WR_DATA)                        tmo_cnt <= TW'(TMO_CYC);
      else if (state == ST_WAIT_DONE && tmo_cnt != 0) tmo_cnt <= tmo_cnt - 1'b1;
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sfrwe     <= 1'b0;
      sfraddr_w <= 3'b000;
      spidata_o <= 8'h00;
      sfraddr_r <= ADDR_SR_R;
      done_q    <= 1'b0;
    end else begin
      sfrwe <= 1'b0;
      if (sfraddr_r == ADDR_SR_R) done_q <= sfrdatai[SR_MDONE_BIT];
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WR_DATA;
            sfrwe     <= 1'b1;
            sfraddr_w <= ADDR_DR1_W;
            spidata_o <= tx_head;
          end
        end
        ST_WR_DATA: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (done_rise) begin
            sfraddr_r <= ADDR_DR2_R;
            state     <= ST_RD_DATA;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_RD_DATA: begin
          sfraddr_r <= ADDR_SR_R;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - randomized self-checking bench for spi_xfer_seq with a behavioural SPI SFR model
module tb_spi_xfer_seq;

  localparam int DEPTH   = 4;
  localparam int TMO_CYC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seq_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       sfrwe;
  logic [2:0] sfraddr_w;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfrdatai;
  logic       busy;
  logic [$clog2(DEPTH):0] tx_level;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic       tmo_err;
`endif

  int errors = 0;
  int checks = 0;

  spi_xfer_seq #(.DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .seq_en(seq_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .spidata_o(spidata_o),
    .sfraddr_r(sfraddr_r), .sfrdatai(sfrdatai), .busy(busy),
`ifdef SPI_SEQ_TIMEOUT_EN
    .tmo_err(tmo_err),
`endif
    .tx_level(tx_level)
  );

  always #5 clk = ~clk;

  // SPI SFR model: a write to SPIDR1 clears master-done, which rises lat cycles later;
  // SPIDR2 returns the reply function of the byte written.
  logic       auto_mode = 1'b1;
  logic       sr_manual = 1'b0;
  logic       sr_done = 1'b0;
  logic [7:0] dr2 = 8'h00;
  int         lat = 20;
  int         cnt = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic       in_flight = 1'b0;
  logic       overlap_seen = 1'b0;
  logic [7:0] wr_log [$];

  function automatic logic [7:0] resp(input logic [7:0] b);
    return b ^ 8'h99;
  endfunction

  assign sfrdatai = (sfraddr_r == 3'b011) ? {7'b0, (auto_mode ? sr_done : sr_manual)} :
                    (sfraddr_r == 3'b101) ? dr2 : 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        sr_done  <= 1'b1;
        rise_cyc <= cyc + 1;
      end
    end
    if (sfraddr_r == 3'b101 || rst) in_flight <= 1'b0;
    if (sfrwe && !rst) begin
      sr_done <= 1'b0;
      dr2     <= resp(spidata_o);
      cnt     <= lat;
      wr_log.push_back(spidata_o);
      if (in_flight) overlap_seen <= 1'b1;
      in_flight <= 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k;
    tx_data  = b;
    tx_valid = 1'b1;
    for (k = 0; k < 500 && !tx_ready; k++) tick();
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL push_wait: tx_ready=%0b after %0d cycles, required 1", tx_ready, k);
    end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_sfrwe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sfrwe) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (rx_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (sfrwe !== 1'b0)       begin errors++; $display("FAIL rst_sfrwe: got %b want 0", sfrwe); end
    checks++; if (sfraddr_w !== 3'b000) begin errors++; $display("FAIL rst_sfraddr_w: got %b want 000", sfraddr_w); end
    checks++; if (spidata_o !== 8'h00)  begin errors++; $display("FAIL rst_spidata_o: got %h want 00", spidata_o); end
    checks++; if (sfraddr_r !== 3'b011) begin errors++; $display("FAIL rst_sfraddr_r: got %b want 011", sfraddr_r); end
    checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (tx_level !== '0)      begin errors++; $display("FAIL rst_tx_level: got %0d want 0", tx_level); end
`ifdef SPI_SEQ_TIMEOUT_EN
    checks++; if (tmo_err !== 1'b0)     begin errors++; $display("FAIL rst_tmo_err: got %b want 0", tmo_err); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    lat = 20; auto_mode = 1'b1; seq_en = 1'b1; rx_ready = 1'b0;
    push_byte(8'hA5);
    wait_sfrwe(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_sfrwe: no write strobe, required one"); end
    checks++; if (sfraddr_w !== 3'b011) begin errors++; $display("FAIL single_addr: got %b want 011", sfraddr_w); end
    checks++; if (spidata_o !== 8'hA5)  begin errors++; $display("FAIL single_data: got %h want a5", spidata_o); end
    tick();
    checks++; if (sfrwe !== 1'b0) begin errors++; $display("FAIL single_pulse: sfrwe %b one cycle later, want 0", sfrwe); end
    wait_rx(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rx_wait: rx_valid never set"); end
    checks++; if (cyc - rise_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", cyc - rise_cyc); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h want 3c", rx_data); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  task automatic test_fill;
    logic [7:0] got [$];
    int n0;
    seq_en = 1'b0; rx_ready = 1'b1; lat = $urandom_range(4, 25);
    n0 = wr_log.size();
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL fill_tx_ready: got %b want 0", tx_ready); end
    checks++; if (tx_level !== 3'd4) begin errors++; $display("FAIL fill_tx_level: got %0d want 4", tx_level); end
    overlap_seen = 1'b0;
    seq_en = 1'b1;
    for (int k = 0; k < 2000 && got.size() < 4; k++) begin
      if (rx_valid) got.push_back(rx_data);
      tick();
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL fill_rx_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== resp(8'(i + 1))) begin errors++; $display("FAIL fill_rx[%0d]: got %h want %h", i, got[i], resp(8'(i + 1))); end
    end
    for (int i = 0; i < 4 && n0 + i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[n0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL fill_wr[%0d]: got %h want %h", i, wr_log[n0 + i], 8'(i + 1)); end
    end
    checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL fill_overlap: write issued before previous completion"); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    localparam int N = 12;
    seq_en = 1'b1; lat = $urandom_range(3, 12);
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          push_byte(b);
          exp_q.push_back(resp(b));
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int k = 0; k < 4000 && got.size() < N; k++) begin
          rx_ready = 1'($urandom_range(0, 1));
          #1;
          if (rx_valid && rx_ready) got.push_back(rx_data);
          tick();
        end
        rx_ready = 1'b0;
      end
    join
    checks++; if (got.size() != N) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got.size(), N); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_rx_full;
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    int n;
    rx_ready = 1'b0; seq_en = 1'b1; lat = 5;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      push_byte(b);
      exp_q.push_back(resp(b));
    end
    for (int k = 0; k < 500 && busy; k++) tick();
    n = wr_log.size();
    push_byte(8'h55);
    exp_q.push_back(resp(8'h55));
    repeat (30) tick();
    checks++; if (wr_log.size() != n) begin errors++; $display("FAIL rxfull_stall: %0d writes while RX full, want 0", wr_log.size() - n); end
    checks++; if (tx_level !== 3'd1) begin errors++; $display("FAIL rxfull_tx_level: got %0d want 1", tx_level); end
    checks++; if (rx_data !== exp_q[0]) begin errors++; $display("FAIL rxfull_head: got %h want %h", rx_data, exp_q[0]); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    checks++; if (sfrwe !== 1'b0) begin errors++; $display("FAIL rxfull_early: sfrwe %b same cycle as pop, want 0", sfrwe); end
    tick();
    checks++; if (sfrwe !== 1'b1) begin errors++; $display("FAIL rxfull_resume: sfrwe %b one cycle after pop, want 1", sfrwe); end
    checks++; if (spidata_o !== 8'h55) begin errors++; $display("FAIL rxfull_data: got %h want 55", spidata_o); end
    rx_ready = 1'b1;
    for (int k = 0; k < 500 && got.size() < 4; k++) begin
      if (rx_valid) got.push_back(rx_data);
      tick();
    end
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_q[i + 1]) begin
        errors++;
        $display("FAIL rxfull_rx[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i + 1]);
      end
    end
  endtask

  task automatic test_done_high;
    bit ok;
    logic [7:0] b;
    b = 8'($urandom);
    auto_mode = 1'b0; sr_manual = 1'b1; rx_ready = 1'b1; seq_en = 1'b1;
    push_byte(b);
    wait_sfrwe(ok);
    checks++; if (!ok) begin errors++; $display("FAIL dhigh_sfrwe: no write strobe"); end
    repeat (10) tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL dhigh_no_push: rx_valid %b with level held high, want 0", rx_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dhigh_busy: got %b want 1", busy); end
    sr_manual = 1'b0; tick(); tick();
    sr_manual = 1'b1;
    wait_rx(ok);
    checks++; if (!ok || rx_data !== resp(b)) begin errors++; $display("FAIL dhigh_rx: got %h valid %b want %h", rx_data, rx_valid, resp(b)); end
    tick();
    sr_manual = 1'b0; auto_mode = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    auto_mode = 1'b1; lat = 40; rx_ready = 1'b1; seq_en = 1'b1;
    n = wr_log.size();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    for (int k = 0; k < 50 && wr_log.size() == n; k++) tick();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (tx_level !== '0)      begin errors++; $display("FAIL rmid_tx_level: got %0d want 0", tx_level); end
    checks++; if (sfraddr_r !== 3'b011) begin errors++; $display("FAIL rmid_sfraddr_r: got %b want 011", sfraddr_r); end
    checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); end
    n = wr_log.size();
    repeat (60) tick();
    checks++; if (rx_valid !== 1'b0 || wr_log.size() != n) begin
      errors++; $display("FAIL rmid_quiet: rx_valid %b writes %0d after reset, want 0 and 0", rx_valid, wr_log.size() - n);
    end
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int k;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    auto_mode = 1'b0; sr_manual = 1'b0; rx_ready = 1'b1; seq_en = 1'b1;
    push_byte(b1);
    wait_sfrwe(ok);
    for (k = 0; k < 60 && !tmo_err; k++) tick();
    checks++; if (k != TMO_CYC + 1) begin errors++; $display("FAIL tmo_time: tmo_err after %0d cycles, want %0d", k, TMO_CYC + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy %b want 0", busy); end
    push_byte(b2);
    wait_sfrwe(ok);
    checks++; if (!ok || spidata_o !== b2) begin errors++; $display("FAIL tmo_next: got %h want %h", spidata_o, b2); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL tmo_no_push: rx_valid %b want 0", rx_valid); end
    repeat (3) tick();
    sr_manual = 1'b1;
    wait_rx(ok);
    checks++; if (!ok || rx_data !== resp(b2)) begin errors++; $display("FAIL tmo_rx: got %h want %h", rx_data, resp(b2)); end
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
    tick();
    sr_manual = 1'b0; auto_mode = 1'b1;
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_rx_full();
    test_done_high();
    test_reset_mid();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
